// File: rtl/make_sched_pkg.sv
// make_sched_pkg: constants, state encoding and helper functions shared by
// the packet-build scheduler (make_sched) and its round-robin finder.
//   - BAG_* : builder packet type codes
//   - COM_RAM_ADDR_* : COM RAM start address of each packet buffer
//   - SLEN/HLEN/DLEN : status length, data header length, per-device payload
//   - state_t : scheduler FSM encoding
package make_sched_pkg;

    localparam logic [3:0] BAG_STAT = 4'h1;
    localparam logic [3:0] BAG_DATA = 4'h5;

    localparam logic [15:0] COM_RAM_ADDR_DATA0 = 16'h0000;
    localparam logic [15:0] COM_RAM_ADDR_DATA1 = 16'h2400;
    localparam logic [15:0] COM_RAM_ADDR_DATA2 = 16'h4800;
    localparam logic [15:0] COM_RAM_ADDR_DATA3 = 16'h6C00;
    localparam logic [15:0] COM_RAM_ADDR_DATA4 = 16'h9000;
    localparam logic [15:0] COM_RAM_ADDR_DATA5 = 16'hB400;
    localparam logic [15:0] COM_RAM_ADDR_STAT  = 16'h2300;

    localparam logic [15:0] SLEN = 16'd14;
    localparam logic [15:0] HLEN = 16'd4;
    localparam logic [15:0] DLEN = 16'd512;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_CLEAR = 2'd2,
        ST_POST  = 2'd3
    } state_t;

    // COM RAM start address of data slot k (slots are 0x2400 bytes apart).
    function automatic logic [15:0] data_addr(input logic [3:0] k);
        case (k)
            4'd0:    data_addr = COM_RAM_ADDR_DATA0;
            4'd1:    data_addr = COM_RAM_ADDR_DATA1;
            4'd2:    data_addr = COM_RAM_ADDR_DATA2;
            4'd3:    data_addr = COM_RAM_ADDR_DATA3;
            4'd4:    data_addr = COM_RAM_ADDR_DATA4;
            4'd5:    data_addr = COM_RAM_ADDR_DATA5;
            default: data_addr = {12'd0, k} * 16'h2400;
        endcase
    endfunction

    // Data packet length: header plus one payload block per present device.
    function automatic logic [15:0] data_len(input logic [7:0] mask);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {15'd0, mask[i]};
        end
        data_len = HLEN + DLEN * n;
    endfunction

endpackage

// File: rtl/make_sched_rr_pick.sv
// make_sched_rr_pick: combinational round-robin first-eligible finder.
// Searches req_i upward starting just after ptr_i, wrapping at N
// (ptr+1 .. N-1, 0 .. ptr). ptr_i must be in 0..N-1.
//   req_i   [N]  eligible requests
//   ptr_i   [IW] last granted index
//   gnt_o   [IW] granted index (0 when nothing is eligible)
//   valid_o      a request was found
module make_sched_rr_pick #(
    parameter int N  = 6,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] gnt_o,
    output logic          valid_o
);

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= N) s = s - N;
        wrap_idx = IW'(s);
    endfunction

    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        // Offset N lands back on ptr itself, so it is searched last.
        for (int i = 1; i <= N; i++) begin
            if (!valid_o && req_i[wrap_idx(ptr_i, i)]) begin
                gnt_o   = wrap_idx(ptr_i, i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/make_sched.sv
// make_sched: schedules status and ADC-data packet builds into the COM RAM.
// Status requests win over data; data slots are served round-robin. A slot
// (or the status buffer) stays busy from its pick until tx_free releases it.
//
// Handshakes:
//   make_fs/make_fd : four-phase. make_fs is raised only while make_fd is
//                     low and held until make_fd is seen; make_fs then drops
//                     and the scheduler waits for make_fd to return low.
//   tx_req/tx_ack   : tx_req with tx_btype/tx_idx/tx_addr/tx_len held
//                     stable until a one-cycle tx_ack pulse.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   data_rdy[NSLOT]   slot k of the ADC cache filled (pulse)
//   stat_req          status packet requested (pulse)
//   dev_mask[8]       present devices, sampled at build pick
//   make_fs/btype/idx builder start and packet selection
//   make_fd           builder done
//   tx_req/btype/idx/addr/len, tx_ack   post to the transmit side
//   tx_free[NSLOT+1]  release data slot k / status buffer (bit NSLOT)
//   busy              scheduler not idle
//   ovf               data_rdy hit an already pending slot (pulse)
//   timeout_err       build aborted for lack of make_fd (pulse)
//   dbg_state         current FSM state
module make_sched
    import make_sched_pkg::*;
#(
    parameter int          NSLOT   = 6,
    parameter logic [15:0] TIMEOUT = 16'd8192
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NSLOT-1:0] data_rdy,
    input  logic             stat_req,
    input  logic [7:0]       dev_mask,
    output logic             make_fs,
    output logic [3:0]       make_btype,
    output logic [3:0]       make_idx,
    input  logic             make_fd,
    output logic             tx_req,
    output logic [3:0]       tx_btype,
    output logic [3:0]       tx_idx,
    output logic [15:0]      tx_addr,
    output logic [15:0]      tx_len,
    input  logic             tx_ack,
    input  logic [NSLOT:0]   tx_free,
    output logic             busy,
    output logic             ovf,
    output logic             timeout_err,
    output state_t           dbg_state
);

    localparam int IW = $clog2(NSLOT);

    state_t           state_q, state_d;
    logic [NSLOT-1:0] pending_q, pending_d;
    logic             stat_pending_q, stat_pending_d;
    logic [NSLOT:0]   slot_busy_q, slot_busy_d;
    logic [NSLOT:0]   cur_oh_q, cur_oh_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic [3:0]       btype_q, btype_d;
    logic [3:0]       idx_q, idx_d;
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      len_q, len_d;
    logic [15:0]      timer_q, timer_d;
    logic             post_valid_q, post_valid_d;
    logic             timeout_q, timeout_d;
    logic             ovf_q, ovf_d;

    logic [NSLOT-1:0] elig_data;
    logic             elig_stat;
    logic [IW-1:0]    gnt;
    logic             gnt_valid;
    logic [NSLOT:0]   pick_oh;
    logic [NSLOT:0]   to_clr;

    assign elig_data = pending_q & ~slot_busy_q[NSLOT-1:0];
    assign elig_stat = stat_pending_q & ~slot_busy_q[NSLOT];

    make_sched_rr_pick #(.N(NSLOT), .IW(IW)) u_rr_pick (
        .req_i   (elig_data),
        .ptr_i   (rr_q),
        .gnt_o   (gnt),
        .valid_o (gnt_valid)
    );

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        btype_d      = btype_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cur_oh_d     = cur_oh_q;
        timer_d      = '0;
        post_valid_d = post_valid_q;
        timeout_d    = 1'b0;
        pick_oh      = '0;
        to_clr       = '0;
        make_fs      = 1'b0;
        tx_req       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The make_fd guard keeps a start from overlapping a builder
                // that is still finishing after a reset.
                if (!make_fd) begin
                    if (elig_stat) begin
                        pick_oh[NSLOT] = 1'b1;
                        btype_d        = BAG_STAT;
                        idx_d          = 4'd0;
                        addr_d         = COM_RAM_ADDR_STAT;
                        len_d          = SLEN;
                        cur_oh_d       = pick_oh;
                        post_valid_d   = 1'b0;
                        state_d        = ST_START;
                    end else if (gnt_valid) begin
                        pick_oh[gnt]   = 1'b1;
                        rr_d           = gnt;
                        btype_d        = BAG_DATA;
                        idx_d          = 4'(gnt);
                        addr_d         = data_addr(4'(gnt));
                        len_d          = data_len(dev_mask);
                        cur_oh_d       = pick_oh;
                        post_valid_d   = 1'b0;
                        state_d        = ST_START;
                    end
                end
            end
            ST_START: begin
                make_fs = 1'b1;
                timer_d = timer_q + 16'd1;
                if (make_fd) begin
                    post_valid_d = 1'b1;
                    state_d      = ST_CLEAR;
                end else if (timer_q == TIMEOUT - 16'd1) begin
                    // Aborted request is dropped, and its buffer is freed
                    // at once since nothing will be transmitted from it.
                    timeout_d    = 1'b1;
                    to_clr       = cur_oh_q;
                    post_valid_d = 1'b0;
                    state_d      = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (!make_fd) begin
                    state_d = post_valid_q ? ST_POST : ST_IDLE;
                end
            end
            ST_POST: begin
                tx_req = 1'b1;
                if (tx_ack) begin
                    post_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // New requests OR in after the pick clear, so a same-cycle set wins.
    assign pending_d      = (pending_q & ~pick_oh[NSLOT-1:0]) | data_rdy;
    assign stat_pending_d = (stat_pending_q & ~pick_oh[NSLOT]) | stat_req;
    assign slot_busy_d    = (slot_busy_q & ~tx_free & ~to_clr) | pick_oh;
    assign ovf_d          = |(data_rdy & pending_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            pending_q      <= '0;
            stat_pending_q <= 1'b0;
            slot_busy_q    <= '0;
            cur_oh_q       <= '0;
            rr_q           <= IW'(NSLOT - 1);
            btype_q        <= '0;
            idx_q          <= '0;
            addr_q         <= '0;
            len_q          <= '0;
            timer_q        <= '0;
            post_valid_q   <= 1'b0;
            timeout_q      <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            stat_pending_q <= stat_pending_d;
            slot_busy_q    <= slot_busy_d;
            cur_oh_q       <= cur_oh_d;
            rr_q           <= rr_d;
            btype_q        <= btype_d;
            idx_q          <= idx_d;
            addr_q         <= addr_d;
            len_q          <= len_d;
            timer_q        <= timer_d;
            post_valid_q   <= post_valid_d;
            timeout_q      <= timeout_d;
            ovf_q          <= ovf_d;
        end
    end

    assign make_btype  = btype_q;
    assign make_idx    = idx_q;
    assign tx_btype    = btype_q;
    assign tx_idx      = idx_q;
    assign tx_addr     = addr_q;
    assign tx_len      = len_q;
    assign busy        = (state_q != ST_IDLE);
    assign ovf         = ovf_q;
    assign timeout_err = timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_make_sched.sv
module tb_make_sched;
    import make_sched_pkg::*;

    localparam int NSLOT = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main DUT (default TIMEOUT) ----------------
    logic [NSLOT-1:0] data_rdy = '0;
    logic             stat_req = 1'b0;
    logic [7:0]       dev_mask = 8'h0F;
    logic             make_fs;
    logic [3:0]       make_btype, make_idx;
    logic             make_fd = 1'b0;
    logic             tx_req;
    logic [3:0]       tx_btype, tx_idx;
    logic [15:0]      tx_addr, tx_len;
    logic             tx_ack = 1'b0;
    logic [NSLOT:0]   tx_free = '0;
    logic             busy, ovf, timeout_err;
    state_t           dbg_state;

    make_sched #(.NSLOT(NSLOT)) u_dut (
        .clk(clk), .rst(rst), .data_rdy(data_rdy), .stat_req(stat_req),
        .dev_mask(dev_mask), .make_fs(make_fs), .make_btype(make_btype),
        .make_idx(make_idx), .make_fd(make_fd), .tx_req(tx_req),
        .tx_btype(tx_btype), .tx_idx(tx_idx), .tx_addr(tx_addr),
        .tx_len(tx_len), .tx_ack(tx_ack), .tx_free(tx_free), .busy(busy),
        .ovf(ovf), .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // ---------------- second DUT with TIMEOUT=16, silent builder ----------------
    logic [NSLOT-1:0] data_rdy_t = '0;
    logic             stat_req_t = 1'b0;
    logic [7:0]       dev_mask_t = 8'h01;
    logic             make_fs_t;
    logic [3:0]       make_btype_t, make_idx_t;
    logic             make_fd_t = 1'b0;
    logic             tx_req_t;
    logic [3:0]       tx_btype_t, tx_idx_t;
    logic [15:0]      tx_addr_t, tx_len_t;
    logic             tx_ack_t = 1'b0;
    logic [NSLOT:0]   tx_free_t = '0;
    logic             busy_t, ovf_t, timeout_err_t;
    state_t           dbg_state_t;

    make_sched #(.NSLOT(NSLOT), .TIMEOUT(16'd16)) u_dut_to (
        .clk(clk), .rst(rst), .data_rdy(data_rdy_t), .stat_req(stat_req_t),
        .dev_mask(dev_mask_t), .make_fs(make_fs_t), .make_btype(make_btype_t),
        .make_idx(make_idx_t), .make_fd(make_fd_t), .tx_req(tx_req_t),
        .tx_btype(tx_btype_t), .tx_idx(tx_idx_t), .tx_addr(tx_addr_t),
        .tx_len(tx_len_t), .tx_ack(tx_ack_t), .tx_free(tx_free_t), .busy(busy_t),
        .ovf(ovf_t), .timeout_err(timeout_err_t), .dbg_state(dbg_state_t)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [7:0]  exp_start_q[$];   // {btype, idx}
    logic [39:0] exp_post_q[$];    // {btype, idx, addr, len}

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Monitor: compares each builder start and each transmit post against
    // the expected queues as the DUT presents them.
    logic prev_fs  = 1'b0;
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        if (make_fs && !prev_fs) begin
            if (exp_start_q.size() == 0)
                fail_now("unexpected_start", $sformatf("got btype %0h idx %0d, expected none", make_btype, make_idx));
            else
                check("start", {32'd0, make_btype, make_idx}, {32'd0, exp_start_q.pop_front()});
        end
        if (tx_req && !prev_req) begin
            if (exp_post_q.size() == 0)
                fail_now("unexpected_post", $sformatf("got addr %0h len %0d, expected none", tx_addr, tx_len));
            else
                check("post", {tx_btype, tx_idx, tx_addr, tx_len}, exp_post_q.pop_front());
        end
        prev_fs  = make_fs;
        prev_req = tx_req;
    end

    int ovf_cnt = 0;
    always @(negedge clk) if (ovf) ovf_cnt++;

    logic tx_seen_t = 1'b0;
    always @(negedge clk) if (tx_req_t) tx_seen_t = 1'b1;

    // ---------------- builder / transmit models ----------------
    logic fd_en = 1'b1;
    initial begin
        int k;
        forever begin
            @(negedge clk);
            if (make_fs && !make_fd && fd_en) begin
                repeat (19) @(negedge clk);
                make_fd = 1'b1;
                k = 0;
                while (make_fs && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                if (k >= 100) fail_now("fs_drop", "make_fs still high 100 cycles after make_fd");
                make_fd = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (tx_req) begin
                @(negedge clk);
                tx_ack = 1'b1;
                @(negedge clk);
                tx_ack = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_data(input logic [NSLOT-1:0] m, input logic s);
        @(posedge clk); #1;
        data_rdy = m;
        stat_req = s;
        @(posedge clk); #1;
        data_rdy = '0;
        stat_req = 1'b0;
    endtask

    task automatic pulse_free(input logic [NSLOT:0] m);
        @(posedge clk); #1;
        tx_free = m;
        @(posedge clk); #1;
        tx_free = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (!(exp_start_q.size() == 0 && exp_post_q.size() == 0 && !busy) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k >= 1000) begin
            n_errors++;
            $display("FAIL %s: still busy after 1000 cycles, %0d starts and %0d posts outstanding",
                     name, exp_start_q.size(), exp_post_q.size());
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k, c0, c1, base;
        logic seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_make_fs", {39'd0, make_fs}, 40'd0);
        check("rst_tx_req", {39'd0, tx_req}, 40'd0);
        check("rst_busy", {39'd0, busy}, 40'd0);
        check("rst_flags", {38'd0, ovf, timeout_err}, 40'd0);
        check("rst_tx_fields", {tx_btype, tx_idx, tx_addr, tx_len}, 40'd0);
        check("rst_to_busy", {39'd0, busy_t}, 40'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single data slot 2, four devices: len = 4 + 4*512 = 2052
        exp_start_q.push_back({BAG_DATA, 4'd2});
        exp_post_q.push_back({BAG_DATA, 4'd2, 16'h4800, 16'd2052});
        pulse_data(6'b000100, 1'b0);
        @(negedge clk);
        check("fs_cycle1", {39'd0, make_fs}, 40'd0);
        @(negedge clk);
        check("fs_cycle2", {39'd0, make_fs}, 40'd1);
        check("fs_sel", {32'd0, make_btype, make_idx}, {32'd0, 4'h5, 4'd2});
        wait_idle("slot2_done");
        @(negedge clk);
        check("busy_after_ack", {39'd0, busy}, 40'd0);
        pulse_free(7'b0000100);

        // Status and slot 0 together: status first
        exp_start_q.push_back({BAG_STAT, 4'd0});
        exp_start_q.push_back({BAG_DATA, 4'd0});
        exp_post_q.push_back({BAG_STAT, 4'd0, 16'h2300, 16'd14});
        exp_post_q.push_back({BAG_DATA, 4'd0, 16'h0000, 16'd2052});
        pulse_data(6'b000001, 1'b1);
        wait_idle("stat_then_data");
        pulse_free(7'b1000001);

        // Round-robin from reset pointer 5: order 1, 3, 5
        do_reset();
        exp_start_q.push_back({BAG_DATA, 4'd1});
        exp_start_q.push_back({BAG_DATA, 4'd3});
        exp_start_q.push_back({BAG_DATA, 4'd5});
        exp_post_q.push_back({BAG_DATA, 4'd1, 16'h2400, 16'd2052});
        exp_post_q.push_back({BAG_DATA, 4'd3, 16'h6C00, 16'd2052});
        exp_post_q.push_back({BAG_DATA, 4'd5, 16'hB400, 16'd2052});
        base = ovf_cnt;
        pulse_data(6'b101010, 1'b0);
        k = 0;
        while (!(make_fs && make_idx == 4'd1) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) fail_now("slot1_start", "slot 1 build never started");
        pulse_data(6'b000010, 1'b0);   // slot 1 busy: stays pending
        pulse_data(6'b000010, 1'b0);   // already pending: overflow
        wait_idle("rr_order");
        check("ovf_count", 40'(ovf_cnt - base), 40'd1);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (make_fs) seen = 1'b1;
        end
        check("no_rebuild_before_free", {39'd0, seen}, 40'd0);
        exp_start_q.push_back({BAG_DATA, 4'd1});
        exp_post_q.push_back({BAG_DATA, 4'd1, 16'h2400, 16'd2052});
        pulse_free(7'b0000010);
        wait_idle("rebuild_after_free");

        // Timeout on the TIMEOUT=16 instance
        @(posedge clk); #1;
        data_rdy_t = 6'b010000;
        @(posedge clk); #1;
        data_rdy_t = '0;
        k = 0;
        while (!make_fs_t && k < 20) begin
            @(negedge clk);
            k++;
        end
        c0 = cyc;
        check("to_fs_rise", {39'd0, make_fs_t}, 40'd1);
        check("to_sel", {32'd0, make_btype_t, make_idx_t}, {32'd0, 4'h5, 4'd4});
        k = 0;
        while (!timeout_err_t && k < 40) begin
            @(negedge clk);
            k++;
        end
        c1 = cyc;
        check("to_seen", {39'd0, timeout_err_t}, 40'd1);
        check("to_delay", 40'(c1 - c0), 40'd16);
        @(negedge clk);
        check("to_pulse_width", {39'd0, timeout_err_t}, 40'd0);
        repeat (5) @(negedge clk);
        check("to_no_tx", {39'd0, tx_seen_t}, 40'd0);
        @(posedge clk); #1;
        data_rdy_t = 6'b010000;
        @(posedge clk); #1;
        data_rdy_t = '0;
        @(negedge clk);
        @(negedge clk);
        check("to_slot_reuse", {39'd0, make_fs_t}, 40'd1);

        // Reset during START
        fd_en = 1'b0;
        exp_start_q.push_back({BAG_DATA, 4'd0});
        pulse_data(6'b000001, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_fs_before", {39'd0, make_fs}, 40'd1);
        pulse_data(6'b000100, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_fs", {39'd0, make_fs}, 40'd0);
        check("rst_mid_tx_busy", {38'd0, tx_req, busy}, 40'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        fd_en = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (make_fs || tx_req) seen = 1'b1;
        end
        check("rst_no_spurious", {39'd0, seen}, 40'd0);
        check("rst_queues_empty", 40'(exp_start_q.size() + exp_post_q.size()), 40'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/make_sched.md
Name: make_sched

Overview:
- Scheduler and controller for the packet builder (fs/fd handshake, btype/data_idx select) that assembles status and ADC-data packets into the COM RAM.
- Collects "data slot ready" events from the ADC cache and status requests, and arbitrates them: status has priority, data slots are served round-robin.
- Drives the builder's start/done handshake, then posts each finished packet (address, length) to the transmit side.
- Blocks rebuilding a COM RAM slot until the transmitter frees it.

Parameters:
- NSLOT, 6, number of ADC/COM data slots (indices 0..NSLOT-1).
- TIMEOUT, 16'd8192, maximum clk cycles to wait for make_fd before aborting a build.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- data_rdy  in  NSLOT  one-cycle pulse per slot; ADC cache slot k is filled.
- stat_req  in  1  one-cycle pulse; a status packet is requested.
- dev_mask  in  8  active-device mask (bit i = device i present); sampled at build start.
- make_fs  out  1  builder start; held high until make_fd seen.
- make_btype  out  4  4'h1 = status, 4'h5 = data.
- make_idx  out  4  data slot index for the builder.
- make_fd  in  1  builder done; stays high until make_fs drops.
- tx_req  out  1  packet ready for transmit; held until tx_ack.
- tx_btype  out  4  type of the posted packet.
- tx_idx  out  4  slot of the posted packet (0 for status).
- tx_addr  out  16  COM RAM start address of the packet.
- tx_len  out  16  packet length in bytes.
- tx_ack  in  1  transmit side accepted the post (one-cycle pulse).
- tx_free  in  NSLOT+1  one-cycle pulse; bit k releases data slot k, bit NSLOT releases the status buffer.
- busy  out  1  high in any state other than IDLE.
- ovf  out  1  one-cycle pulse when data_rdy[k] arrives while pending[k] is already set.
- timeout_err  out  1  one-cycle pulse when a build is aborted.

Behaviour:
- Reset values: all outputs 0; pending, slot_busy and stat_pending cleared; rr pointer = NSLOT-1; state IDLE. A reset mid-build drops make_fs and tx_req immediately.
- Bookkeeping:
  - data_rdy[k] sets pending[k]; stat_req sets stat_pending.
  - A set in the same cycle as a clear (pick) wins: the request stays pending.
  - tx_free[k] clears slot_busy[k].
- Eligibility: stat_pending & ~slot_busy[NSLOT]; data slot k: pending[k] & ~slot_busy[k].
- State machine:
  - IDLE: when anything is eligible, go to START next edge.
    - Status wins over data.
    - Otherwise choose the first eligible slot after rr, searching upward with wrap (rr+1 .. NSLOT-1, 0 .. rr).
    - On the pick: clear the pending bit, set slot_busy, update rr (data only), register btype/idx, and capture len = 16'd14 (status) or 16'd4 + 16'd512 * popcount(dev_mask) (data).
  - START: make_fs=1; btype/idx held stable.
    - make_fd=1 -> CLEAR, setting post-valid.
    - Timer reaching TIMEOUT-1 without make_fd -> pulse timeout_err, clear slot_busy of the picked slot (request dropped, not re-queued) -> CLEAR without post-valid.
  - CLEAR: make_fs=0; wait for make_fd=0. Then go to POST if post-valid, else IDLE.
  - POST: tx_req=1 with tx_btype/tx_idx/tx_addr/tx_len stable; tx_ack -> IDLE. slot_busy stays set until tx_free.
- Addresses: data slot k -> k * 16'h2400 (0x0000, 0x2400, ... 0xB400); status -> 16'h2300.
- Latency: with the scheduler idle, a data_rdy pulse in cycle 0 gives pending in cycle 1 and make_fs high in cycle 2.
- make_fs rises only when make_fd is low; no back-to-back start without a CLEAR.
- data_rdy for a busy slot stays pending and is served after tx_free.
- ovf does not alter the pending state.
- Out-of-range indices are never generated.

Decomposition:
- Shared package holds:
  - BAG_STAT = 4'h1, BAG_DATA = 4'h5.
  - COM_RAM_ADDR_DATA0..5 and COM_RAM_ADDR_STAT.
  - SLEN = 14, HLEN = 4, DLEN = 512.
  - The state encodings.
- One natural sub-module: rr_pick, a combinational round-robin first-eligible finder (req vector, pointer -> grant index, valid).

Test Plan:
- data_rdy[2] pulse, dev_mask=8'h0F, builder model answers fd after 20 cycles:
  - make_fs rises in cycle 2 with btype=5, idx=2.
  - tx_req follows with addr=0x4800, len=2052.
  - After tx_ack, busy=0.
- stat_req and data_rdy[0] in the same cycle -> status built first (addr 0x2300, len 14), then slot 0 (addr 0x0000).
- data_rdy[5], data_rdy[1], data_rdy[3] together from reset (rr=5) -> service order 0-none, giving 1, 3, 5.
  - A second data_rdy[1] before tx_free[1] -> slot 1 is rebuilt only after tx_free[1].
  - data_rdy[1] again while pending[1] is set -> ovf pulses once.
- Builder never asserts fd, TIMEOUT=16 -> timeout_err pulses 16 cycles after make_fs rise, no tx_req, slot reusable immediately.
- rst asserted while in START -> make_fs=0 immediately; after release, pending=0 and no spurious tx_req.
